// File: rtl/add_nbit_pipe.sv
`default_nettype none
// ============================================================================
// Module      : add_nbit_pipe
// Description : Pipelined N-bit adder/subtractor. The operands are split into
//               SEG-bit segments and one segment is resolved per stage, with
//               the segment carry registered between stages. Each stage has a
//               valid/ready handshake, so backpressure is taken one stage at a
//               time and throughput is one result per cycle. The last stage is
//               the output register.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH      operand/result width; must be a multiple of SEG
//   SEG        bits resolved per stage (STAGES = WIDTH/SEG, minimum 1)
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand set present
//   in_ready   operand set accepted this cycle (forced 0 while in reset)
//   a, b       operands
//   cin        carry-in for add (ignored when sub=1)
//   sub        0: a+b+cin   1: a-b computed as a+~b+1
//   out_valid  result present
//   out_ready  downstream accepts the result
//   sum        result modulo 2^WIDTH
//   cout       carry out of the MSB (for sub, 1 = no borrow)
//   ovf        signed overflow (carry into MSB xor carry out of MSB)
// Build option
//   ADD_NBIT_PIPE_SAT_EN  when defined, sum saturates to the signed limit
//                         whenever ovf=1 (cout and ovf are unaffected)
// ============================================================================
module add_nbit_pipe #(
  parameter int WIDTH = 8,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = ((WIDTH / SEG) < 1) ? 1 : (WIDTH / SEG);
  localparam int LAST   = STAGES - 1;
  // Skew storage exists only between stages; keep at least one entry so the
  // declaration stays legal for the single-stage build.
  localparam int SKEW_N = (STAGES > 1) ? (STAGES - 1) : 1;

`ifdef ADD_NBIT_PIPE_SAT_EN
  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  // --------------------------------------------------------------------------
  // Pipeline state
  // --------------------------------------------------------------------------
  logic [STAGES-1:0] valid_q;          // stage k holds a live operand set
  logic [STAGES-1:0] carry_q;          // carry out of segment k
  logic [WIDTH-1:0]  sum_q [STAGES];   // bits [(k+1)*SEG-1:0] resolved
  logic [WIDTH-1:0]  a_q   [SKEW_N];   // operand A travelling with stage k
  logic [WIDTH-1:0]  b_q   [SKEW_N];   // effective B (already inverted for sub)
  logic              ovf_q;            // final-stage overflow flag

  logic [STAGES:0]   stage_ready;      // stage_ready[STAGES] is the sink
  logic [WIDTH-1:0]  b_eff;
  logic              cin0;
  logic              ovf_d;

  // Subtraction is a + ~b + 1: invert B once at the entry and force the
  // stage-0 carry, so every later stage is a plain adder.
  assign b_eff = sub ? ~b : b;
  assign cin0  = sub | cin;

  // A stage can load when it is empty or when its content leaves this cycle.
  // The chain is resolved from the sink backwards in one block so that the
  // whole ready path is a single combinational process.
  always_comb begin
    stage_ready         = '0;
    stage_ready[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      stage_ready[k] = !valid_q[k] || stage_ready[k+1];
    end
  end

  // Stage 0 is empty and therefore "ready" during reset, so the reset level
  // masks in_ready explicitly.
  assign in_ready = stage_ready[0] & rst_n;

  // --------------------------------------------------------------------------
  // Per-stage segment adders and registers
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SEG-1:0]   seg_a;
    logic [SEG-1:0]   seg_b;
    logic             seg_cin;
    logic             src_v;
    logic [WIDTH-1:0] src_sum;
    logic [SEG:0]     seg_res;
    logic [WIDTH-1:0] sum_d;

    if (k == 0) begin : g_head
      assign seg_a   = a[SEG-1:0];
      assign seg_b   = b_eff[SEG-1:0];
      assign seg_cin = cin0;
      assign src_v   = in_valid;
      assign src_sum = '0;

      if (STAGES > 1) begin : g_skew
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            a_q[0] <= '0;
            b_q[0] <= '0;
          end else if (stage_ready[0] && in_valid) begin
            a_q[0] <= a;
            b_q[0] <= b_eff;
          end
        end
      end
    end else begin : g_body
      assign seg_a   = a_q[k-1][k*SEG +: SEG];
      assign seg_b   = b_q[k-1][k*SEG +: SEG];
      assign seg_cin = carry_q[k-1];
      assign src_v   = valid_q[k-1];
      assign src_sum = sum_q[k-1];

      if (k < LAST) begin : g_skew
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
          end else if (stage_ready[k] && valid_q[k-1]) begin
            a_q[k] <= a_q[k-1];
            b_q[k] <= b_q[k-1];
          end
        end
      end
    end

    assign seg_res = {1'b0, seg_a} + {1'b0, seg_b} + {{SEG{1'b0}}, seg_cin};

    // Lower segments come from the previous stage; this stage fills its own.
    always_comb begin
      sum_d                = src_sum;
      sum_d[k*SEG +: SEG]  = seg_res[SEG-1:0];
`ifdef ADD_NBIT_PIPE_SAT_EN
      // Overflow implies both effective operands share a sign; that sign
      // selects the limit the true result ran past.
      if ((k == LAST) && ovf_d) begin
        sum_d = seg_a[SEG-1] ? SAT_NEG : SAT_POS;
      end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q[k] <= 1'b0;
        carry_q[k] <= 1'b0;
        sum_q[k]   <= '0;
      end else if (stage_ready[k]) begin
        valid_q[k] <= src_v;
        if (src_v) begin
          carry_q[k] <= seg_res[SEG];
          sum_q[k]   <= sum_d;
        end
      end
    end

    if (k == LAST) begin : g_tail
      logic msb_carry;

      // Carry into bit WIDTH-1 recovered from the MSB sum bit:
      // s = a ^ b ^ c_in  =>  c_in = a ^ b ^ s.
      assign msb_carry = seg_a[SEG-1] ^ seg_b[SEG-1] ^ seg_res[SEG-1];
      assign ovf_d     = msb_carry ^ seg_res[SEG];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (stage_ready[k] && src_v) begin
          ovf_q <= ovf_d;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs straight from the final-stage flops
  // --------------------------------------------------------------------------
  assign out_valid = valid_q[LAST];
  assign sum       = sum_q[LAST];
  assign cout      = carry_q[LAST];
  assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_add_nbit_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_add_nbit_pipe
// Description : Self-checking bench for add_nbit_pipe (WIDTH=8, SEG=4).
//               Directed vector table, backpressure stream, mid-flight reset
//               and a randomised handshake stream against a scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_add_nbit_pipe;

  localparam int WIDTH    = 8;
  localparam int SEG      = 4;
  localparam int STAGES   = WIDTH / SEG;
  localparam int MAX_WAIT = 20;
  localparam int NVEC     = 13;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  always #5 clk = ~clk;

  add_nbit_pipe #(
    .WIDTH(WIDTH),
    .SEG  (SEG)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] sum_wrap;
    logic [7:0] sum_sat;
    logic       cout;
    logic       ovf;
  } vec_t;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } res_t;

  vec_t vecs [NVEC];
  res_t expq [$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_sum(input vec_t v);
`ifdef ADD_NBIT_PIPE_SAT_EN
    return v.sum_sat;
`else
    return v.sum_wrap;
`endif
  endfunction

  // Reference arithmetic for the random stream: 9-bit sum for cout, 8-bit
  // sum of the low seven bits for the carry into the sign bit.
  function automatic res_t model(input logic [7:0] ia, input logic [7:0] ib,
                                 input logic icin, input logic isub);
    logic [7:0] be;
    logic       c;
    logic [8:0] full;
    logic [7:0] low;
    res_t       r;
    be     = isub ? ~ib : ib;
    c      = isub ? 1'b1 : icin;
    full   = {1'b0, ia} + {1'b0, be} + {8'd0, c};
    low    = {1'b0, ia[6:0]} + {1'b0, be[6:0]} + {7'd0, c};
    r.sum  = full[7:0];
    r.cout = full[8];
    r.ovf  = low[7] ^ full[8];
`ifdef ADD_NBIT_PIPE_SAT_EN
    if (r.ovf) r.sum = ia[7] ? 8'h80 : 8'h7F;
`endif
    return r;
  endfunction

  // One transaction through an empty pipeline with latency measurement.
  task automatic run_one(input int idx);
    int lat;
    bit seen;
    @(posedge clk); #1;
    a         = vecs[idx].a;
    b         = vecs[idx].b;
    cin       = vecs[idx].cin;
    sub       = vecs[idx].sub;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check($sformatf("v%0d_in_ready", idx), 32'(in_ready), 32'd1);
    @(posedge clk); #1;          // accepted at this edge
    in_valid = 1'b0;
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < MAX_WAIT && !seen; i++) begin
      if (out_valid) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    check($sformatf("v%0d_latency", idx), 32'(lat), 32'(STAGES - 1));
    if (seen) begin
      check($sformatf("v%0d_sum", idx),  32'(sum),  32'(exp_sum(vecs[idx])));
      check($sformatf("v%0d_cout", idx), 32'(cout), 32'(vecs[idx].cout));
      check($sformatf("v%0d_ovf", idx),  32'(ovf),  32'(vecs[idx].ovf));
      @(posedge clk); #1;
      check($sformatf("v%0d_drained", idx), 32'(out_valid), 32'd0);
    end
  endtask

  // Streaming run. rnd=0: first n table vectors back-to-back with a 3-cycle
  // output stall from the first out_valid. rnd=1: random operands, random
  // in_valid / out_ready at 50%.
  task automatic stream(input int n, input bit rnd);
    int   sent, got, cyc, stall_left;
    bit   acc, emit, ov_seen, inready_low;
    res_t r, e;
    sent = 0; got = 0; cyc = 0; stall_left = 0;
    acc = 1'b0; ov_seen = 1'b0; inready_low = 1'b0;
    expq.delete();
    in_valid = 1'b0;
    while (got < n && cyc < n * 12 + 60) begin
      @(posedge clk); #1;
      cyc++;
      if (acc) in_valid = 1'b0;
      if (!in_valid && sent < n && (!rnd || $urandom_range(1, 0) == 1)) begin
        if (rnd) begin
          a   = 8'($urandom);
          b   = 8'($urandom);
          cin = 1'($urandom);
          sub = 1'($urandom);
        end else begin
          a   = vecs[sent].a;
          b   = vecs[sent].b;
          cin = vecs[sent].cin;
          sub = vecs[sent].sub;
        end
        in_valid = 1'b1;
      end
      if (!rnd && !ov_seen && out_valid) begin
        ov_seen    = 1'b1;
        stall_left = 3;
      end
      if (rnd) out_ready = ($urandom_range(1, 0) == 1);
      else begin
        out_ready = (stall_left == 0);
        if (stall_left > 0) stall_left--;
      end
      #1;
      if (!rnd && out_valid && !out_ready) begin
        check("hold_has_entry", 32'(expq.size() > 0), 32'd1);
        if (expq.size() > 0) begin
          check("hold_sum",  32'(sum),  32'(expq[0].sum));
          check("hold_cout", 32'(cout), 32'(expq[0].cout));
          check("hold_ovf",  32'(ovf),  32'(expq[0].ovf));
        end
      end
      if (in_valid && !in_ready) inready_low = 1'b1;
      acc  = in_valid && in_ready;
      emit = out_valid && out_ready;
      if (emit) begin
        check("out_has_entry", 32'(expq.size() > 0), 32'd1);
        if (expq.size() > 0) begin
          e = expq.pop_front();
          check($sformatf("s%0d_sum", got),  32'(sum),  32'(e.sum));
          check($sformatf("s%0d_cout", got), 32'(cout), 32'(e.cout));
          check($sformatf("s%0d_ovf", got),  32'(ovf),  32'(e.ovf));
          got++;
        end
      end
      if (acc) begin
        if (rnd) r = model(a, b, cin, sub);
        else begin
          r.sum  = exp_sum(vecs[sent]);
          r.cout = vecs[sent].cout;
          r.ovf  = vecs[sent].ovf;
        end
        expq.push_back(r);
        sent++;
      end
    end
    check("stream_count", 32'(got), 32'(n));
    if (!rnd) check("inready_dropped", 32'(inready_low), 32'd1);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("stream_no_extra", 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          a      b      cin   sub   wrap   sat    cout  ovf
    vecs[0]  = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 8'h7F, 1'b0, 1'b1};
    vecs[1]  = '{8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[2]  = '{8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 8'hF0, 1'b0, 1'b0};
    vecs[3]  = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 8'h80, 1'b1, 1'b1};
    vecs[4]  = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[5]  = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0};
    vecs[6]  = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 8'h80, 1'b1, 1'b1};
    vecs[7]  = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 8'h10, 1'b0, 1'b0};
    vecs[8]  = '{8'h05, 8'h05, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[9]  = '{8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0};
    vecs[10] = '{8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 8'h7F, 1'b0, 1'b1};
    vecs[11] = '{8'h3C, 8'hC4, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[12] = '{8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum",       32'(sum),       32'd0);
    check("rst_cout",      32'(cout),      32'd0);
    check("rst_ovf",       32'(ovf),       32'd0);
    rst_n = 1'b1;

    // Directed table through an empty pipeline
    for (int i = 0; i < NVEC; i++) run_one(i);

    // Backpressure stream: 4 back-to-back with a 3-cycle output stall
    stream(4, 1'b0);

    // Reset with two transactions in flight
    @(posedge clk); #1;
    a = vecs[0].a; b = vecs[0].b; cin = vecs[0].cin; sub = vecs[0].sub;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    a = vecs[7].a; b = vecs[7].b; cin = vecs[7].cin; sub = vecs[7].sub;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pre_reset_valid", 32'(out_valid), 32'd1);
    check("pre_reset_sum",   32'(sum),       32'(exp_sum(vecs[0])));
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_sum",       32'(sum),       32'd0);
    check("mid_rst_cout",      32'(cout),      32'd0);
    check("mid_rst_ovf",       32'(ovf),       32'd0);
    check("mid_rst_in_ready",  32'(in_ready),  32'd0);
    @(posedge clk); #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      check("post_rst_no_stale", 32'(out_valid), 32'd0);
    end
    run_one(3);

    // Random handshake stream against the scoreboard
    stream(1000, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/add_nbit_pipe.md
Name: add_nbit_pipe

Overview:
- Parametrised, pipelined N-bit adder/subtractor for the multiplier library; successor to the combinational per-bit half-adder array.
- Operand is split into SEG-bit segments; one segment resolves per pipeline stage and the carry is registered between stages.
- valid/ready handshake on both sides with full backpressure; throughput of one result per cycle.
- Used as the final carry-propagate adder behind the partial-product stages of the Vedic multiplier.

Parameters:
- WIDTH, 8, operand and result width in bits; must be a multiple of SEG.
- SEG, 4, bits resolved per stage; STAGES = WIDTH/SEG (minimum 1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand set present.
- in_ready  output  1  block accepts the operand set this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  0: a+b+cin; 1: a-b, computed as a+~b+1.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry out of the MSB; for sub, 1 means no borrow.
- ovf  output  1  signed two's-complement overflow, equal to carry into MSB XOR carry out of MSB.

Behaviour:
- Reset: asynchronous on the falling edge of rst_n; all stage valids cleared; out_valid=0, sum=0, cout=0, ovf=0. in_ready is forced 0 while rst_n is low.
- Transfer rule: a transfer occurs on a clock edge when valid and ready are both high. Input side uses in_valid & in_ready; output side uses out_valid & out_ready.
- Stage k (k = 0..STAGES-1) holds:
  - valid_k;
  - resolved sum bits [(k+1)*SEG-1:0];
  - registered carry;
  - the unresolved upper segments of a and ~b/b (skew registers);
  - the final stage also holds ovf.
- Stage loading: stage k loads when ready_k = !valid_k || ready_(k+1), where ready_STAGES = out_ready. in_ready = ready_0.
- Output register: stage STAGES-1 is the output register, so sum, cout, ovf and out_valid come directly from flops.
- Latency: operands accepted at edge T appear with out_valid=1 after edge T+STAGES-1, i.e. STAGES cycles from acceptance, with no stalls.
- Stalls:
  - out_ready=0 with out_valid=1: the output register holds sum, cout and ovf stable.
  - Upstream stages continue to fill bubbles.
  - in_ready falls only when every stage is valid and blocked.
- Simultaneous accept and emit: a stage emitting and loading in the same cycle is legal; there is no bubble and no duplication.
- Ordering: results emerge in acceptance order; no drops or duplicates under any in_valid/out_ready pattern.
- in_valid=1 with in_ready=0: the operands are not captured, and the source must hold them.
- Carry chain:
  - Stage 0 carry-in is sub ? 1 : cin.
  - The segment carry-out of stage k is the carry-in of stage k+1 on the next transfer.
  - The MSB-segment internal carry into bit WIDTH-1 is kept for the ovf computation.
- Boundary case STAGES=1: the block degenerates to a registered adder with latency 1.
- Wrap-around: sum wraps modulo 2^WIDTH. cout and ovf are reported unconditionally.
- Reset mid-operation: all in-flight results are discarded, with no partial output. The first accepted transfer after release behaves as from an empty pipeline.

Optional Feature:
- Macro: ADD_NBIT_PIPE_SAT_EN.
- Defined: when ovf=1, sum saturates to the signed limit. Positive overflow gives 0x7F...F; negative overflow gives 0x80...0. Saturation is applied in the final stage with no added latency. cout and ovf are unchanged.
- Undefined: sum wraps as specified above, and there is no saturation logic.

Test Plan:
- WIDTH=8, SEG=4. a=0x7F, b=0x01, sub=0, cin=0 -> 2 cycles after accept: sum=0x80, cout=0, ovf=1. With ADD_NBIT_PIPE_SAT_EN: sum=0x7F, ovf=1.
- a=0xFF, b=0x00, cin=1, sub=0 -> sum=0x00, cout=1, ovf=0. The carry crosses the segment boundary between stages.
- a=0x10, b=0x20, sub=1, cin=1 -> sum=0xF0, cout=0, ovf=0 (cin ignored). a=0x80, b=0x01, sub=1 -> sum=0x7F, cout=1, ovf=1; with the macro, sum=0x80.
- Stream of 4 back-to-back transactions, with out_ready held 0 for 3 cycles from the first out_valid:
  - the output holds its value;
  - in_ready drops once both stages are full;
  - all 4 results appear in order with correct values, with no loss or duplication.
- Random in_valid/out_ready at 50% each, 1000 transactions -> scoreboard matches a+b+cin or a-b modulo 256, with matching cout/ovf.
- rst_n pulsed low for 1 cycle with 2 transactions in flight -> out_valid=0 and sum/cout/ovf=0 immediately. No stale result emerges afterward. The next transaction has a latency of exactly 2 cycles.
